// File: rtl/seq_div.sv
// seq_div: 32-bit unsigned restoring divider, one quotient bit per cycle.
// Fixed latency; divide-by-zero short-circuits straight to DONE.
module seq_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [5:0]       cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] dvd_nx;
   logic             qbit;
   logic             last;
   logic             take;

   // sh is the 33-bit partial remainder; a borrow out of diff means sh < dvs
   always_comb begin
      sh     = {rem, dvd[WIDTH-1]};
      diff   = sh - {1'b0, dvs};
      qbit   = ~diff[WIDTH];
      rem_nx = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      dvd_nx = {dvd[WIDTH-2:0], qbit};
      last   = (cnt == 6'(WIDTH - 1));
      take   = (state == IDLE) && start;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = (B == '0) ? DONE : CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= '0;
         rem         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (take) begin
         cnt <= '0;
         rem <= '0;
         dvd <= A;
         dvs <= B;
         if (B == '0) begin
            quotient    <= '1;
            remainder   <= A;
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         cnt <= cnt + 6'd1;
         rem <= rem_nx;
         dvd <= dvd_nx;
         if (last) begin
            quotient    <= dvd_nx;
            remainder   <= rem_nx;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule
